// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Oversampling is fixed at 16 s_ticks per bit; the start bit is confirmed at its midpoint.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

endpackage

// File: rtl/bit_sync.sv
// Multi-stage synchronizer for a single asynchronous input.
// The reset value is a parameter so idle-high lines come out of reset inactive.
module bit_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: recovers LSB-first frames from a 16x-oversampled rx line and
// reports each word with a one-cycle done strobe plus framing-error and break status.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DBIT        = 8,
    parameter int SB_TICK     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            break_det
);

    localparam int NW = $clog2(DBIT);

    localparam logic [4:0]    MID_S  = 5'(MID_START);
    localparam logic [4:0]    LAST_S = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]    STOP_S = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] LAST_N = NW'(DBIT - 1);

    rx_state_t       state;
    logic [4:0]      s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shift;
    logic            rx_s;

    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Single FSM: counters advance only on s_tick, except the IDLE->START
    // transition which reacts immediately so back-to-back frames are not missed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shift        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == MID_S) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == LAST_S) begin
                            shift <= {rx_s, shift[DBIT-1:1]};
                            s     <= '0;
                            if (n == LAST_N) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                STOP: begin
                    // A low stop bit leaves the line low; park in WAIT_HIGH so a
                    // held-low line cannot be mistaken for a new start bit.
                    if (s_tick) begin
                        if (s == STOP_S) begin
                            dout         <= shift;
                            frame_err    <= ~rx_s;
                            break_det    <= ~rx_s && (shift == '0);
                            rx_done_tick <= 1'b1;
                            state        <= rx_s ? IDLE : WAIT_HIGH;
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Testbench for uart_rx_sampler: directed and random frames driven on rx,
// received words compared against a queue of expected records built from frame contents.
module tb_uart_rx_sampler;

    localparam int CLK_PER_TICK = 4;
    localparam int CLK_PER_BIT  = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       brk;
    } rec_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       break_det;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   total;
    int   bad;
    int   double_cnt;
    int   tick_cnt;
    logic prev_tick;

    uart_rx_sampler #(
        .DBIT        (8),
        .SB_TICK     (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .break_det    (break_det)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        s_tick   = 1'b0;
        tick_cnt = 0;
        forever begin
            @(negedge clk);
            tick_cnt = (tick_cnt == CLK_PER_TICK - 1) ? 0 : tick_cnt + 1;
            s_tick   = (tick_cnt == CLK_PER_TICK - 1);
        end
    end

    // Record every done strobe and flag any strobe lasting two cycles.
    initial begin
        double_cnt = 0;
        prev_tick  = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_done_tick === 1'b1) begin
                obs_q.push_back('{data: dout, ferr: frame_err, brk: break_det});
                if (prev_tick === 1'b1) double_cnt = double_cnt + 1;
            end
            prev_tick = rx_done_tick;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total = total + 1;
        assert (observed === expected)
        else begin
            bad = bad + 1;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic line_for(input logic level, input int bits);
        rx = level;
        repeat (CLK_PER_BIT * bits) @(negedge clk);
    endtask

    // One frame on the line; the expected record follows directly from the frame contents.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_high,
                                 input int low_bits, input int gap_bits);
        line_for(1'b0, 1);
        for (int i = 0; i < 8; i++) line_for(data[i], 1);
        if (stop_high) line_for(1'b1, 1);
        else           line_for(1'b0, low_bits);
        line_for(1'b1, gap_bits);
        exp_q.push_back('{data: data, ferr: !stop_high, brk: !stop_high && (data == 8'h00)});
    endtask

    task automatic checkOutput(input string tag);
        rec_t o;
        rec_t e;
        repeat (8) @(negedge clk);
        check_value({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check_value({tag, "_dout"}, 32'(o.data), 32'(e.data));
            check_value({tag, "_ferr"}, 32'(o.ferr), 32'(e.ferr));
            check_value({tag, "_brk"},  32'(o.brk),  32'(e.brk));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rdata;
        bit         rstop;
        int         rgap;
        total = 0;
        bad   = 0;
        rx    = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_value("reset_dout", 32'(dout), 32'h0);
        check_value("reset_done", 32'(rx_done_tick), 32'h0);
        check_value("reset_ferr", 32'(frame_err), 32'h0);
        check_value("reset_brk",  32'(break_det), 32'h0);
        reset = 1'b0;
        line_for(1'b1, 2);

        $display("[TB] single frame 0x55");
        applyStimulus(8'h55, 1'b1, 1, 2);
        checkOutput("frame55");

        $display("[TB] back-to-back 0xA5, 0x3C");
        applyStimulus(8'hA5, 1'b1, 1, 0);
        applyStimulus(8'h3C, 1'b1, 1, 2);
        checkOutput("b2b");

        $display("[TB] start glitch then 0x81");
        rx = 1'b0;
        repeat (3 * CLK_PER_TICK) @(negedge clk);
        line_for(1'b1, 1);
        applyStimulus(8'h81, 1'b1, 1, 2);
        checkOutput("glitch");

        $display("[TB] framing error 0xF0 then 0x12");
        applyStimulus(8'hF0, 1'b0, 2, 2);
        checkOutput("ferrF0");
        check_value("hold_ferr", 32'(frame_err), 32'h1);
        applyStimulus(8'h12, 1'b1, 1, 2);
        checkOutput("after_ferr");

        $display("[TB] break then 0x7E");
        line_for(1'b0, 20);
        exp_q.push_back('{data: 8'h00, ferr: 1'b1, brk: 1'b1});
        line_for(1'b1, 2);
        checkOutput("break");
        applyStimulus(8'h7E, 1'b1, 1, 2);
        checkOutput("after_break");

        $display("[TB] reset during data bit 4 of 0x0F");
        line_for(1'b0, 1);
        for (int i = 0; i < 4; i++) line_for(1'(i < 4), 1);
        rx = 1'b0;
        repeat (CLK_PER_BIT / 2) @(negedge clk);
        // The transmitter also goes idle so the tail of the aborted frame is not re-framed.
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        line_for(1'b1, 2);
        checkOutput("reset_abort");
        check_value("abort_dout", 32'(dout), 32'h0);
        check_value("abort_ferr", 32'(frame_err), 32'h0);
        check_value("abort_brk",  32'(break_det), 32'h0);
        applyStimulus(8'h0F, 1'b1, 1, 2);
        checkOutput("after_reset");

        $display("[TB] random frames");
        for (int k = 0; k < 12; k++) begin
            rdata = 8'($urandom_range(0, 255));
            if (k == 3) rdata = 8'h00;
            rstop = ($urandom_range(0, 3) != 0);
            rgap  = rstop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            applyStimulus(rdata, rstop, int'($urandom_range(1, 2)), rgap);
        end
        line_for(1'b1, 1);
        checkOutput("random");

        check_value("no_double_tick", 32'(double_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
